// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
//   state_t      parser FSM states
//   frame_hdr_t  CMD/LEN pair of a frame
//   is_set_baud  decides whether a completed frame may update baud_set
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] len;
  } frame_hdr_t;

  localparam logic [7:0] CMD_SET_BAUD = 8'h01;
  localparam logic [2:0] BAUD_MAX     = 3'd4;
  localparam logic [7:0] HDR0_DEF     = 8'h55;
  localparam logic [7:0] HDR1_DEF     = 8'hAA;

  // Only a one-byte set-baud payload with a legal selection reprograms the receiver.
  function automatic logic is_set_baud(input frame_hdr_t h, input logic [2:0] sel);
    return (h.cmd == CMD_SET_BAUD) && (h.len == 8'd1) && (sel <= BAUD_MAX);
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog for the frame parser.
//   clk, reset_n  clock, async active-low reset
//   clr           restart the count (byte seen, or parser idle); wins over tc
//   en            count while a frame is in progress
//   tc            one-cycle terminal-count pulse at TIMEOUT_CYCLES-1
// TIMEOUT_CYCLES must be at least 2.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  assign tc = en && !clr && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      cnt <= '0;
    else if (clr || tc) cnt <= '0;
    else if (en)       cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame-level parser behind the UART byte receiver.
// Frame: HDR0 HDR1 CMD LEN PAYLOAD[LEN] [CSUM]
//   clk, reset_n      clock, async active-low reset
//   rx_data/rx_valid  byte strobe from the receiver
//   rd_addr/rd_data   combinational payload buffer read port (0 beyond MAX_LEN)
//   frame_valid       1-cycle pulse per good frame; frame_cmd/frame_len hold its CMD/LEN
//   baud_set          receiver baud selection, updated by set-baud frames
//   busy              parser not idle
//   err_csum/err_len/err_timeout  1-cycle error pulses
// Build option UART_FRAME_CSUM_EN: when defined, a trailing checksum byte
// (sum of CMD, LEN and payload, mod 256) is required and checked; when
// undefined the frame ends on its last payload byte (or on LEN when LEN is 0),
// frame_valid comes one clock later and err_csum is always 0.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] HDR0           = HDR0_DEF,
  parameter logic [7:0] HDR1           = HDR1_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       frame_valid,
  output logic [7:0]                 frame_cmd,
  output logic [7:0]                 frame_len,
  output logic [2:0]                 baud_set,
  output logic                       busy,
  output logic                       err_csum,
  output logic                       err_len,
  output logic                       err_timeout
);

  localparam int         AW       = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);
`ifdef UART_FRAME_CSUM_EN
  localparam int STAGES = 0;
`else
  localparam int STAGES = 1;
`endif
  localparam int PW = STAGES + 1;

  state_t                  state;
  frame_hdr_t              hdr_q;    // frame being parsed
  frame_hdr_t              last_q;   // last good frame
  logic [AW-1:0]           idx;
  logic [MAX_LEN-1:0][7:0] pbuf;
  logic [PW-1:0]           vld_q;
  logic [PW-1:0]           vld_pipe;
  logic                    done;
  logic                    last_byte;
  logic                    tc;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]              acc;
`endif

  uart_frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rx_valid || (state == ST_IDLE)),
    .en      (state != ST_IDLE),
    .tc      (tc)
  );

  assign last_byte = (8'(idx) == hdr_q.len - 8'd1);

  // Byte that completes a good frame.
  always_comb begin
    done = 1'b0;
    if (rx_valid) begin
`ifdef UART_FRAME_CSUM_EN
      done = (state == ST_CSUM) && (rx_data == acc);
`else
      done = ((state == ST_LEN) && (rx_data == 8'd0)) ||
             ((state == ST_PAYLOAD) && last_byte);
`endif
    end
  end

  // vld_pipe[0] is the completing byte itself; vld_pipe[STAGES] is the edge
  // at which the frame is committed and frame_valid gets loaded.
  assign vld_pipe    = (vld_q << 1) | PW'(done);
  assign frame_valid = vld_q[STAGES];
  assign frame_cmd   = last_q.cmd;
  assign frame_len   = last_q.len;
  assign busy        = (state != ST_IDLE);
  assign rd_data     = (int'(rd_addr) < MAX_LEN) ? pbuf[rd_addr] : 8'h00;
`ifndef UART_FRAME_CSUM_EN
  assign err_csum    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      hdr_q       <= '0;
      last_q      <= '0;
      idx         <= '0;
      pbuf        <= '0;
      vld_q       <= '0;
      baud_set    <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      acc         <= '0;
      err_csum    <= 1'b0;
`endif
    end else begin
      vld_q       <= vld_pipe;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      err_csum    <= 1'b0;
`endif

      if (vld_pipe[STAGES]) begin
        last_q <= hdr_q;
        if (is_set_baud(hdr_q, pbuf[0][2:0])) baud_set <= pbuf[0][2:0];
      end

      if (rx_valid) begin
        unique case (state)
          ST_IDLE: if (rx_data == HDR0) state <= ST_HDR1;
          ST_HDR1: begin
            // A repeated HDR0 keeps us aligned on the newest header start.
            if (rx_data == HDR1)      state <= ST_CMD;
            else if (rx_data != HDR0) state <= ST_IDLE;
          end
          ST_CMD: begin
            hdr_q.cmd <= rx_data;
`ifdef UART_FRAME_CSUM_EN
            acc       <= rx_data;
`endif
            state     <= ST_LEN;
          end
          ST_LEN: begin
            hdr_q.len <= rx_data;
            idx       <= '0;
`ifdef UART_FRAME_CSUM_EN
            acc       <= acc + rx_data;
`endif
            if (rx_data > MAX_LEN8) begin
              err_len <= 1'b1;
              state   <= ST_IDLE;
            end else if (rx_data == 8'd0) begin
`ifdef UART_FRAME_CSUM_EN
              state <= ST_CSUM;
`else
              state <= ST_IDLE;
`endif
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            pbuf[idx] <= rx_data;
            idx       <= idx + AW'(1);
`ifdef UART_FRAME_CSUM_EN
            acc       <= acc + rx_data;
            if (last_byte) state <= ST_CSUM;
`else
            if (last_byte) state <= ST_IDLE;
`endif
          end
          ST_CSUM: begin
`ifdef UART_FRAME_CSUM_EN
            if (rx_data != acc) err_csum <= 1'b1;
`endif
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (tc) begin
        err_timeout <= 1'b1;
        state       <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TO      = 40;
`ifdef UART_FRAME_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [7:0] frame_len;
  logic [2:0] baud_set;
  logic       busy;
  logic       err_csum;
  logic       err_len;
  logic       err_timeout;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
    .frame_cmd(frame_cmd), .frame_len(frame_len), .baud_set(baud_set),
    .busy(busy), .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fv = 0, n_ecs = 0, n_el = 0, n_eto = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // frm holds the bytes of the frame accepted so far (empty = idle).
  logic [7:0] frm[$];
  int         idle = 0;
  bit         pend = 1'b0;
  logic [7:0] p_cmd, p_len, p_b0;
  logic [7:0] m_buf[MAX_LEN];
  bit         m_bv[MAX_LEN];
  logic       m_fv = 0, m_ecs = 0, m_el = 0, m_eto = 0;
  logic [7:0] m_cmd = 0, m_len = 0;
  logic [2:0] m_baud = 0;

  function void commit(input logic [7:0] c, input logic [7:0] l, input logic [7:0] b0);
    m_fv  = 1'b1;
    m_cmd = c;
    m_len = l;
    if (c == 8'h01 && l == 8'd1 && b0[2:0] <= 3'd4) m_baud = b0[2:0];
  endfunction

  function void finish_frame();
    pend  = 1'b1;
    p_cmd = frm[2];
    p_len = frm[3];
    p_b0  = (frm.size() > 4) ? frm[4] : 8'h00;
    frm.delete();
  endfunction

  function void model_byte(input logic [7:0] b);
    int n, L;
    logic [7:0] s;
    n = frm.size();
    if (n == 0) begin
      if (b == 8'h55) frm.push_back(b);
    end else if (n == 1) begin
      if (b == 8'hAA) frm.push_back(b);
      else if (b != 8'h55) frm.delete();
    end else if (n == 2) begin
      frm.push_back(b);
    end else if (n == 3) begin
      frm.push_back(b);
      if (int'(b) > MAX_LEN) begin m_el = 1'b1; frm.delete(); end
      else if (b == 8'd0 && !CSUM) finish_frame();
    end else begin
      L = int'(frm[3]);
      if (n < 4 + L) begin
        m_buf[n-4] = b;
        m_bv[n-4]  = 1'b1;
        frm.push_back(b);
        if (!CSUM && n == 3 + L) finish_frame();
      end else begin
        s = 8'h00;
        for (int i = 2; i < n; i++) s = 8'(s + frm[i]);
        if (s == b) commit(frm[2], frm[3], (n > 4) ? frm[4] : 8'h00);
        else m_ecs = 1'b1;
        frm.delete();
      end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frm.delete();
      idle = 0; pend = 1'b0;
      m_fv = 0; m_ecs = 0; m_el = 0; m_eto = 0;
      m_cmd = 0; m_len = 0; m_baud = 0;
      for (int i = 0; i < MAX_LEN; i++) m_bv[i] = 1'b0;
    end else begin
      m_fv = 0; m_ecs = 0; m_el = 0; m_eto = 0;
      if (pend) begin pend = 1'b0; commit(p_cmd, p_len, p_b0); end
      if (rx_valid) begin
        idle = 0;
        model_byte(rx_data);
      end else if (frm.size() != 0) begin
        idle++;
        if (idle == TO) begin m_eto = 1'b1; frm.delete(); idle = 0; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("frame_cmd",   32'(frame_cmd),   32'(m_cmd));
    chk("frame_len",   32'(frame_len),   32'(m_len));
    chk("baud_set",    32'(baud_set),    32'(m_baud));
    chk("busy",        32'(busy),        32'(frm.size() != 0));
    chk("err_csum",    32'(err_csum),    32'(m_ecs));
    chk("err_len",     32'(err_len),     32'(m_el));
    chk("err_timeout", 32'(err_timeout), 32'(m_eto));
    if (m_bv[rd_addr]) chk("rd_data", 32'(rd_data), 32'(m_buf[rd_addr]));
    if (frame_valid) n_fv++;
    if (err_csum)    n_ecs++;
    if (err_len)     n_el++;
    if (err_timeout) n_eto++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    rd_addr  = 4'($urandom_range(0, MAX_LEN - 1));
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) begin
      rd_addr = 4'($urandom_range(0, MAX_LEN - 1));
      tick();
    end
  endtask

  function automatic int pick_gap(input int maxgap);
    if (maxgap > 0 && $urandom_range(0, 49) == 0) return TO - 2 + int'($urandom_range(0, 2));
    return int'($urandom_range(0, maxgap));
  endfunction

  task automatic send_frame(input logic [7:0] cmd, input bq_t pl, input bit bad, input int maxgap);
    logic [7:0] s;
    s = 8'(cmd + 8'(pl.size()));
    send(8'h55, pick_gap(maxgap));
    send(8'hAA, pick_gap(maxgap));
    send(cmd, pick_gap(maxgap));
    send(8'(pl.size()), pick_gap(maxgap));
    foreach (pl[i]) begin
      s = 8'(s + pl[i]);
      send(pl[i], pick_gap(maxgap));
    end
    if (CSUM) send(bad ? 8'(s - 8'd1) : s, pick_gap(maxgap));
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  initial begin
    int f, e;
    bq_t pl;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'(frame_cmd), 0);
    chk("rst_baud", 32'(baud_set), 0);
    chk("rst_fv", 32'(frame_valid), 0);
    reset_n = 1'b1;
    tick();

    // basic frame with 3-byte payload
    f = n_fv;
    send_frame(8'h10, '{8'h01, 8'h02, 8'h03}, 1'b0, 0);
    settle();
    chk("t1_fv_cnt", 32'(n_fv - f), 1);
    chk("t1_cmd", 32'(frame_cmd), 32'h10);
    chk("t1_len", 32'(frame_len), 3);
    rd_addr = 4'd0; #1 chk("t1_rd0", 32'(rd_data), 32'h01);
    rd_addr = 4'd1; #1 chk("t1_rd1", 32'(rd_data), 32'h02);
    rd_addr = 4'd2; #1 chk("t1_rd2", 32'(rd_data), 32'h03);
    tick();

    // set-baud: legal then illegal selection
    send_frame(8'h01, '{8'h03}, 1'b0, 0);
    settle();
    chk("t2_baud3", 32'(baud_set), 3);
    f = n_fv;
    send_frame(8'h01, '{8'h07}, 1'b0, 0);
    settle();
    chk("t2_fv_cnt", 32'(n_fv - f), 1);
    chk("t2_baud_hold", 32'(baud_set), 3);

`ifdef UART_FRAME_CSUM_EN
    // bad checksum leaves the last good frame untouched
    e = n_ecs; f = n_fv;
    send_frame(8'h10, '{8'h01, 8'h02, 8'h03}, 1'b1, 0);
    settle();
    chk("t3_ecs_cnt", 32'(n_ecs - e), 1);
    chk("t3_fv_cnt", 32'(n_fv - f), 0);
    chk("t3_cmd_hold", 32'(frame_cmd), 32'h01);
    chk("t3_len_hold", 32'(frame_len), 1);
`endif
    send_frame(8'h20, '{}, 1'b0, 0);
    settle();
    chk("t3_cmd0", 32'(frame_cmd), 32'h20);
    chk("t3_len0", 32'(frame_len), 0);

    // oversize LEN, then header re-sync
    e = n_el;
    send(8'h55, 0); send(8'hAA, 0); send(8'h10, 0); send(8'h11, 0);
    tick();
    chk("t4_el_cnt", 32'(n_el - e), 1);
    chk("t4_busy", 32'(busy), 0);
    send(8'h55, 0); send(8'h55, 0); send(8'hAA, 0); send(8'h10, 0); send(8'h00, 0);
    if (CSUM) send(8'h10, 0);
    settle();
    chk("t4_cmd", 32'(frame_cmd), 32'h10);
    chk("t4_len", 32'(frame_len), 0);

    // timeout, then a byte exactly at the terminal count
    e = n_eto;
    send(8'h55, 0); send(8'hAA, 0); send(8'h10, 0); send(8'h02, 0); send(8'h01, 0);
    repeat (TO + 5) tick();
    chk("t5_eto_cnt", 32'(n_eto - e), 1);
    chk("t5_busy", 32'(busy), 0);
    e = n_eto; f = n_fv;
    send(8'h55, 0); send(8'hAA, 0); send(8'h10, 0); send(8'h02, 0);
    send(8'h01, TO - 1);
    send(8'h02, 0);
    if (CSUM) send(8'h15, 0);
    settle();
    chk("t5_tc_eto", 32'(n_eto - e), 0);
    chk("t5_tc_fv", 32'(n_fv - f), 1);

    // async reset mid-payload
    send(8'h55, 0); send(8'hAA, 0); send(8'h10, 0); send(8'h03, 0); send(8'h01, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cmd", 32'(frame_cmd), 0);
    chk("t6_len", 32'(frame_len), 0);
    chk("t6_baud", 32'(baud_set), 0);
    tick();
    reset_n = 1'b1;
    tick();
    f = n_fv;
    send_frame(8'h10, '{8'h01, 8'h02, 8'h03}, 1'b0, 0);
    settle();
    chk("t6_fv_cnt", 32'(n_fv - f), 1);
    chk("t6_cmd2", 32'(frame_cmd), 32'h10);

    // randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      int r, len;
      logic [7:0] cmd;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        send(8'($urandom), int'($urandom_range(0, 3)));
      end else if (r < 10) begin
        send(8'h55, 0); send(8'hAA, 1); send(8'($urandom), 0);
        send(8'($urandom_range(MAX_LEN + 1, 255)), 2);
      end else if (r < 15) begin
        send(8'h55, 0); send(8'hAA, 0); send(8'($urandom), 0); send(8'h05, 0);
        send(8'($urandom), 0);
        repeat (TO + int'($urandom_range(0, 4))) tick();
      end else begin
        cmd = ($urandom_range(0, 2) == 0) ? 8'h01 : 8'($urandom);
        if (cmd == 8'h01 && $urandom_range(0, 3) != 0) len = 1;
        else len = int'($urandom_range(0, MAX_LEN));
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        send_frame(cmd, pl, ($urandom_range(0, 9) == 0), 3);
      end
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
